// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared FSM states, CSR addresses and mstatus bit positions for the trap sequencer
package trap_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_EPC    = 3'd1,
      T_CAUSE  = 3'd2,
      T_TVAL   = 3'd3,
      T_STATUS = 3'd4,
      M_STATUS = 3'd5,
      REDIR    = 3'd6
   } trap_state_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - writeback request, CSR read/write and redirect bundle for trap_sequencer
interface trap_sequencer_if #(
   parameter int XLEN   = 64,
   parameter int CSRA_W = 12
);
   logic              wb_v;
   logic              wb_cs;
   logic [XLEN-1:0]   wb_cause;
   logic [XLEN-1:0]   wb_pc;
   logic [XLEN-1:0]   wb_tval;
   logic              wb_mret;
   logic              wb_st_csr;
   logic [CSRA_W-1:0] wb_csr_addr;
   logic [XLEN-1:0]   wb_csr_data;
   logic [XLEN-1:0]   mtvec;
   logic [XLEN-1:0]   mepc;
   logic [XLEN-1:0]   mstatus;
   logic              csr_we;
   logic [CSRA_W-1:0] csr_waddr;
   logic [XLEN-1:0]   csr_wdata;
   logic              trap_redirect;
   logic [XLEN-1:0]   trap_target;
   logic              pipe_flush;
   logic              wb_stall;

   modport master (
      output wb_v, wb_cs, wb_cause, wb_pc, wb_tval, wb_mret, wb_st_csr,
             wb_csr_addr, wb_csr_data, mtvec, mepc, mstatus,
      input  csr_we, csr_waddr, csr_wdata, trap_redirect, trap_target,
             pipe_flush, wb_stall
   );

   modport slave (
      input  wb_v, wb_cs, wb_cause, wb_pc, wb_tval, wb_mret, wb_st_csr,
             wb_csr_addr, wb_csr_data, mtvec, mepc, mstatus,
      output csr_we, csr_waddr, csr_wdata, trap_redirect, trap_target,
             pipe_flush, wb_stall
   );
endinterface

// File: rtl/trap_target_calc.sv
// rtl/trap_target_calc.sv - combinational trap vector target; vectored interrupts under TRAP_VECTORED_EN
module trap_target_calc
   import trap_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] cause,
   output logic [XLEN-1:0] target
);
   logic [XLEN-1:0] base;

   assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   logic vectored;

   // 4*cause drops cause[XLEN-2] and the interrupt bit; the add wraps at XLEN
   assign vectored = (mtvec[1:0] == MTVEC_MODE_VECTORED) && cause[XLEN-1];
   assign target   = vectored ? base + {cause[XLEN-3:0], 2'b00} : base;
`else
   logic unused_vec_bits;

   assign unused_vec_bits = ^{mtvec[1:0], cause};
   assign target          = base;
`endif
endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - serialises trap/MRET CSR updates onto one write port and issues the PC redirect
// Optional TRAP_VECTORED_EN enables vectored interrupt targets in trap_target_calc.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int CSRA_W = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   trap_sequencer_if.slave bus
);
   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic            mret_q, mret_d;

   logic            take_trap, take_mret, take_csr;
   logic [XLEN-1:0] vec_target;
   logic [XLEN-1:0] trap_mstatus, mret_mstatus;

   logic              csr_we;
   logic [CSRA_W-1:0] csr_waddr;
   logic [XLEN-1:0]   csr_wdata;
   logic              redirect;
   logic [XLEN-1:0]   target;
   logic              flush;
   logic              stall;

   // Trap beats MRET, both beat a plain CSR write
   assign take_trap = (state_q == IDLE) && bus.wb_v && bus.wb_cs;
   assign take_mret = (state_q == IDLE) && bus.wb_v && bus.wb_mret && !bus.wb_cs;
   assign take_csr  = (state_q == IDLE) && bus.wb_v && bus.wb_st_csr && !bus.wb_cs && !bus.wb_mret;

   trap_target_calc #(.XLEN(XLEN)) u_target_calc (
      .mtvec  (mtvec_q),
      .cause  (cause_q),
      .target (vec_target)
   );

   always_comb begin
      trap_mstatus                                 = bus.mstatus;
      trap_mstatus[MSTATUS_MPIE]                   = bus.mstatus[MSTATUS_MIE];
      trap_mstatus[MSTATUS_MIE]                    = 1'b0;
      trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
      mret_mstatus                                 = bus.mstatus;
      mret_mstatus[MSTATUS_MIE]                    = bus.mstatus[MSTATUS_MPIE];
      mret_mstatus[MSTATUS_MPIE]                   = 1'b1;
      mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
         mtvec_q <= '0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
         mtvec_q <= mtvec_d;
         mret_q  <= mret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      mtvec_d = mtvec_q;
      mret_d  = mret_q;
      case (state_q)
         IDLE: begin
            if (take_trap) begin
               pc_d    = bus.wb_pc;
               cause_d = bus.wb_cause;
               tval_d  = bus.wb_tval;
               mtvec_d = bus.mtvec;
               mret_d  = 1'b0;
               state_d = T_EPC;
            end else if (take_mret) begin
               mret_d  = 1'b1;
               state_d = M_STATUS;
            end
         end
         T_EPC:    state_d = T_CAUSE;
         T_CAUSE:  state_d = T_TVAL;
         T_TVAL:   state_d = T_STATUS;
         T_STATUS: state_d = REDIR;
         // pc_q is free on the MRET path, so it carries the return address
         M_STATUS: begin
            pc_d    = bus.mepc;
            state_d = REDIR;
         end
         REDIR:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      csr_we    = 1'b0;
      csr_waddr = '0;
      csr_wdata = '0;
      redirect  = 1'b0;
      target    = '0;
      flush     = (state_q != IDLE);
      stall     = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            flush = take_trap || take_mret;
            if (take_csr) begin
               csr_we    = 1'b1;
               csr_waddr = bus.wb_csr_addr;
               csr_wdata = bus.wb_csr_data;
            end
         end
         T_EPC: begin
            csr_we    = 1'b1;
            csr_waddr = CSRA_W'(CSR_MEPC);
            csr_wdata = {pc_q[XLEN-1:2], 2'b00};
         end
         T_CAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = CSRA_W'(CSR_MCAUSE);
            csr_wdata = cause_q;
         end
         T_TVAL: begin
            csr_we    = 1'b1;
            csr_waddr = CSRA_W'(CSR_MTVAL);
            csr_wdata = tval_q;
         end
         T_STATUS: begin
            csr_we    = 1'b1;
            csr_waddr = CSRA_W'(CSR_MSTATUS);
            csr_wdata = trap_mstatus;
         end
         M_STATUS: begin
            csr_we    = 1'b1;
            csr_waddr = CSRA_W'(CSR_MSTATUS);
            csr_wdata = mret_mstatus;
         end
         REDIR: begin
            redirect = 1'b1;
            target   = mret_q ? pc_q : vec_target;
         end
         default: ;
      endcase
   end

   // Outputs are forced low for the whole time reset is held, even with requests present
   assign bus.csr_we        = rst_n & csr_we;
   assign bus.csr_waddr     = rst_n ? csr_waddr : '0;
   assign bus.csr_wdata     = rst_n ? csr_wdata : '0;
   assign bus.trap_redirect = rst_n & redirect;
   assign bus.trap_target   = rst_n ? target : '0;
   assign bus.pipe_flush    = rst_n & flush;
   assign bus.wb_stall      = rst_n & stall;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   trap_sequencer_if #(.XLEN(64), .CSRA_W(12)) bus ();

   trap_sequencer #(.XLEN(64), .CSRA_W(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req;
      bus.wb_v        = 1'b0;
      bus.wb_cs       = 1'b0;
      bus.wb_mret     = 1'b0;
      bus.wb_st_csr   = 1'b0;
      bus.wb_cause    = '0;
      bus.wb_pc       = '0;
      bus.wb_tval     = '0;
      bus.wb_csr_addr = '0;
      bus.wb_csr_data = '0;
   endtask

   task automatic test_reset;
      clear_req();
      bus.mtvec = '0; bus.mepc = '0; bus.mstatus = '0;
      rst_n = 1'b0;
      bus.wb_v = 1'b1; bus.wb_st_csr = 1'b1;
      bus.wb_csr_addr = 12'h340; bus.wb_csr_data = 64'h55;
      #1;
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bus.csr_we); end
      checks++; if (bus.csr_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.csr_wdata); end
      checks++; if (bus.pipe_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", bus.pipe_flush); end
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", bus.wb_stall); end
      checks++; if (bus.trap_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0b want 0", bus.trap_redirect); end
      clear_req();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0b want 0", bus.wb_stall); end
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL idle_no_req_we: got %0b want 0", bus.csr_we); end
   endtask

   task automatic run_trap(input string tag, input logic [63:0] pc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [63:0] mtvec, input logic [63:0] mstatus,
                           input logic extra_csr, input logic extra_mret,
                           input logic [63:0] exp_epc, input logic [63:0] exp_status,
                           input logic [63:0] exp_target);
      logic [11:0] ea [4];
      logic [63:0] ed [4];
      ea = '{12'h341, 12'h342, 12'h343, 12'h300};
      ed = '{exp_epc, cause, tval, exp_status};
      bus.mtvec = mtvec; bus.mstatus = mstatus;
      bus.wb_v = 1'b1; bus.wb_cs = 1'b1; bus.wb_cause = cause; bus.wb_pc = pc; bus.wb_tval = tval;
      bus.wb_st_csr = extra_csr; bus.wb_mret = extra_mret;
      bus.wb_csr_addr = 12'h340; bus.wb_csr_data = 64'h55;
      #1;
      checks++; if (bus.pipe_flush !== 1'b1) begin errors++; $display("FAIL %s accept_flush: got %0b want 1", tag, bus.pipe_flush); end
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL %s accept_we: got %0b want 0", tag, bus.csr_we); end
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL %s accept_stall: got %0b want 0", tag, bus.wb_stall); end
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) clear_req();
         checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL %s stall c%0d: got %0b want 1", tag, c, bus.wb_stall); end
         checks++; if (bus.pipe_flush !== 1'b1) begin errors++; $display("FAIL %s flush c%0d: got %0b want 1", tag, c, bus.pipe_flush); end
         if (c < 5) begin
            checks++; if (bus.csr_we !== 1'b1) begin errors++; $display("FAIL %s we c%0d: got %0b want 1", tag, c, bus.csr_we); end
            checks++; if (bus.csr_waddr !== ea[c-1]) begin errors++; $display("FAIL %s waddr c%0d: got %h want %h", tag, c, bus.csr_waddr, ea[c-1]); end
            checks++; if (bus.csr_wdata !== ed[c-1]) begin errors++; $display("FAIL %s wdata c%0d: got %h want %h", tag, c, bus.csr_wdata, ed[c-1]); end
            checks++; if (bus.trap_redirect !== 1'b0) begin errors++; $display("FAIL %s early_redirect c%0d: got %0b want 0", tag, c, bus.trap_redirect); end
         end else begin
            checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL %s redir_we: got %0b want 0", tag, bus.csr_we); end
            checks++; if (bus.trap_redirect !== 1'b1) begin errors++; $display("FAIL %s redirect: got %0b want 1", tag, bus.trap_redirect); end
            checks++; if (bus.trap_target !== exp_target) begin errors++; $display("FAIL %s target: got %h want %h", tag, bus.trap_target, exp_target); end
         end
      end
      tick();
      checks++; if (bus.trap_redirect !== 1'b0) begin errors++; $display("FAIL %s redirect_len: got %0b want 0", tag, bus.trap_redirect); end
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL %s idle_stall: got %0b want 0", tag, bus.wb_stall); end
   endtask

   task automatic test_trap_misaligned;
      run_trap("misaligned", 64'h8000_0102, 64'd4, 64'h1003, 64'h8000_1000, 64'h8,
               1'b0, 1'b0, 64'h8000_0100, 64'h1880, 64'h8000_1000);
   endtask

   task automatic test_trap_wins_csr;
      run_trap("trap_vs_csr", 64'h2000_0004, 64'd2, 64'hDEAD, 64'h400, 64'h88,
               1'b1, 1'b0, 64'h2000_0004, 64'h1880, 64'h400);
   endtask

   task automatic test_trap_wins_mret;
      run_trap("trap_vs_mret", 64'h3, 64'd11, 64'h0, 64'h1003, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF7, 64'h1000);
   endtask

   task automatic test_vectored;
      logic [63:0] exp_t;
`ifdef TRAP_VECTORED_EN
      exp_t = 64'h8000_101C;
`else
      exp_t = 64'h8000_1000;
`endif
      run_trap("vectored", 64'h1000, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_1001, 64'h0,
               1'b0, 1'b0, 64'h1000, 64'h1800, exp_t);
   endtask

   task automatic run_mret(input string tag, input logic [63:0] mstatus, input logic [63:0] mepc,
                           input logic [63:0] exp_status);
      bus.mstatus = mstatus; bus.mepc = mepc;
      bus.wb_v = 1'b1; bus.wb_mret = 1'b1;
      #1;
      checks++; if (bus.pipe_flush !== 1'b1) begin errors++; $display("FAIL %s accept_flush: got %0b want 1", tag, bus.pipe_flush); end
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL %s accept_we: got %0b want 0", tag, bus.csr_we); end
      tick();
      clear_req();
      checks++; if (bus.csr_we !== 1'b1) begin errors++; $display("FAIL %s we: got %0b want 1", tag, bus.csr_we); end
      checks++; if (bus.csr_waddr !== 12'h300) begin errors++; $display("FAIL %s waddr: got %h want 300", tag, bus.csr_waddr); end
      checks++; if (bus.csr_wdata !== exp_status) begin errors++; $display("FAIL %s wdata: got %h want %h", tag, bus.csr_wdata, exp_status); end
      checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL %s stall: got %0b want 1", tag, bus.wb_stall); end
      tick();
      bus.mepc = 64'hBAD0;
      #1;
      checks++; if (bus.trap_redirect !== 1'b1) begin errors++; $display("FAIL %s redirect: got %0b want 1", tag, bus.trap_redirect); end
      checks++; if (bus.trap_target !== mepc) begin errors++; $display("FAIL %s target: got %h want %h", tag, bus.trap_target, mepc); end
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL %s redir_we: got %0b want 0", tag, bus.csr_we); end
      tick();
      checks++; if (bus.trap_redirect !== 1'b0) begin errors++; $display("FAIL %s redirect_len: got %0b want 0", tag, bus.trap_redirect); end
   endtask

   task automatic test_mret;
      run_mret("mret_a", 64'h1880, 64'h8000_0200, 64'h1888);
      run_mret("mret_b", 64'h0, 64'h4444_0000, 64'h1880);
   endtask

   task automatic test_csr_write;
      bus.wb_v = 1'b1; bus.wb_st_csr = 1'b1;
      bus.wb_csr_addr = 12'h340; bus.wb_csr_data = 64'h55;
      #1;
      checks++; if (bus.csr_we !== 1'b1) begin errors++; $display("FAIL csr_we: got %0b want 1", bus.csr_we); end
      checks++; if (bus.csr_waddr !== 12'h340) begin errors++; $display("FAIL csr_waddr: got %h want 340", bus.csr_waddr); end
      checks++; if (bus.csr_wdata !== 64'h55) begin errors++; $display("FAIL csr_wdata: got %h want 55", bus.csr_wdata); end
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL csr_stall: got %0b want 0", bus.wb_stall); end
      checks++; if (bus.pipe_flush !== 1'b0) begin errors++; $display("FAIL csr_flush: got %0b want 0", bus.pipe_flush); end
      bus.wb_v = 1'b0;
      #1;
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL csr_wb_v_low: got %0b want 0", bus.csr_we); end
      clear_req();
      tick();
   endtask

   task automatic test_back_to_back;
      bus.mstatus = 64'h80; bus.mepc = 64'h600;
      bus.wb_v = 1'b1; bus.wb_mret = 1'b1;
      tick();
      clear_req();
      tick();
      bus.wb_v = 1'b1; bus.wb_st_csr = 1'b1;
      bus.wb_csr_addr = 12'h305; bus.wb_csr_data = 64'h1234;
      #1;
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL b2b_redir_we: got %0b want 0", bus.csr_we); end
      checks++; if (bus.trap_redirect !== 1'b1) begin errors++; $display("FAIL b2b_redirect: got %0b want 1", bus.trap_redirect); end
      tick();
      checks++; if (bus.csr_we !== 1'b1) begin errors++; $display("FAIL b2b_idle_we: got %0b want 1", bus.csr_we); end
      checks++; if (bus.csr_waddr !== 12'h305) begin errors++; $display("FAIL b2b_waddr: got %h want 305", bus.csr_waddr); end
      checks++; if (bus.csr_wdata !== 64'h1234) begin errors++; $display("FAIL b2b_wdata: got %h want 1234", bus.csr_wdata); end
      clear_req();
      tick();
   endtask

   task automatic test_reset_mid_trap;
      bus.mtvec = 64'h8000_1000; bus.mstatus = 64'h8;
      bus.wb_v = 1'b1; bus.wb_cs = 1'b1; bus.wb_cause = 64'd5;
      bus.wb_pc = 64'h100; bus.wb_tval = 64'h77;
      tick();
      clear_req();
      tick();
      checks++; if (bus.csr_waddr !== 12'h342) begin errors++; $display("FAIL midrst_pre_addr: got %h want 342", bus.csr_waddr); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %0b want 0", bus.csr_we); end
      checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %0b want 0", bus.wb_stall); end
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL midrst_post_we c%0d: got %0b want 0", c, bus.csr_we); end
         checks++; if (bus.trap_redirect !== 1'b0) begin errors++; $display("FAIL midrst_post_redirect c%0d: got %0b want 0", c, bus.trap_redirect); end
      end
   endtask

   initial begin
      test_reset();
      test_trap_misaligned();
      test_mret();
      test_csr_write();
      test_trap_wins_csr();
      test_trap_wins_mret();
      test_vectored();
      test_back_to_back();
      test_reset_mid_trap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
